kmeans_apb_master: RTL and testbench
====================================

Name: kmeans_apb_master

Overview:
- Host-side APB master that drives the K-means accelerator's slave port: pwrite/psel/penable/paddr/pwdata out; pready/prdata/interupt in.
- Accepts read/write commands on a valid/ready stream, buffers them in a small FIFO and executes them as APB transfers.
- Returns read data on a response pulse.
- Latches the accelerator's completion interrupt into a sticky done flag for the host sequencer.

Parameters:
- ADDR_W, 9, APB address width.
- DATA_W, 91, APB data width (7 coordinates x 13 bits).
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- TIMEOUT_CYC, 64, max ACCESS cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse: read completed (or error, see feature).
- rsp_rdata  out  DATA_W  captured prdata, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.
- interupt  in  1  accelerator completion (level).
- done  out  1  sticky completion flag.
- done_clr  in  1  clears done.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; FIFO emptied; FSM to IDLE. Asserted mid-transfer, the transfer is abandoned without a response, psel/penable drop at the next edge, and the FIFO contents are discarded.
- Push occurs when cmd_valid && cmd_ready. No push when full, even if a pop happens the same cycle.
- FIFO is registered: an entry pushed at edge T is visible to the FSM from cycle T+1. Read and write pointers wrap modulo CMD_DEPTH. The count is CMD_DEPTH+1 states wide.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, register pwrite/paddr/pwdata, go to SETUP.
  - SETUP: psel=1, penable=0; go to ACCESS unconditionally.
  - ACCESS: psel=1, penable=1; wait-state while !pready. On pready, the transfer completes that cycle:
    - read: rsp_rdata <= prdata, rsp_valid=1 in the next cycle, rsp_err=0;
    - write: no response.
    - Then, if the FIFO is non-empty, pop and go directly to SETUP (back-to-back, psel stays 1, penable drops); else go to IDLE with psel=0.
- paddr/pwrite/pwdata are held stable throughout SETUP+ACCESS. Outside a transfer they hold their last values.
- Minimum latency: cmd accepted at T -> SETUP at T+1... psel rises at T+2, penable at T+3. With pready at T+3, rsp_valid is at T+4.
- rsp_valid has no backpressure; the host must sink it.
- done: set at edge after a rising edge of interupt (registered edge detect). Cleared by done_clr. Simultaneous set and clear -> done=1 (set wins).
- busy = (state!=IDLE) || !empty.

Optional Feature:
- Macro: KMEANS_APB_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. If pready is still low after TIMEOUT_CYC cycles, the transfer aborts: FSM goes to IDLE (psel=0), and rsp_valid=1 with rsp_err=1 the next cycle for both reads and writes (rsp_rdata=0). The counter resets on each SETUP.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.

Decomposition:
- kmeans_pkg:
  - ADDR_W/DATA_W defaults;
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS};
  - packed struct kmeans_cmd_t {write, addr, wdata};
  - TIMEOUT counter width localparam.
- Sub-module: kmeans_cmd_fifo, a synchronous FIFO of kmeans_cmd_t with push/pop/full/empty.

Test Plan:
- Single write addr 0x010, data 91'h1 at T, pready=1 immediately -> psel rises T+2, penable T+3, pwrite=1, paddr=0x010, no rsp_valid; busy=0 at T+4.
- Read addr 0x1FF, pready low 3 cycles, prdata=91'hABC -> penable held 4 cycles, rsp_valid pulse 1 cycle after pready with rsp_rdata=91'hABC.
- Push 5 commands back-to-back with pready=0 -> cmd_ready=0 after 4 accepted plus one in flight; releasing pready executes all in order; psel stays high between transfers.
- Reset asserted during ACCESS with 2 queued -> psel/penable=0 next edge; no rsp_valid; no further transfers after reset release.
- interupt 0->1 with done_clr=1 same cycle -> done=1; done_clr alone next cycle -> done=0; interupt held high -> done not re-set.
- With KMEANS_APB_TIMEOUT_EN, TIMEOUT_CYC=64, pready stuck 0 -> abort after 64 ACCESS cycles; rsp_valid=1, rsp_err=1; next queued command proceeds.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared types and defaults for the K-means accelerator APB host master.
// Command layout, FSM state encoding and timeout counter sizing live here.
package kmeans_pkg;

    localparam int KM_ADDR_W      = 9;
    localparam int KM_DATA_W      = 91;
    localparam int KM_TIMEOUT_CYC = 64;

    function automatic int to_cnt_width(input int cyc);
        return $clog2(cyc + 1);
    endfunction

    localparam int KM_TO_CNT_W = to_cnt_width(KM_TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                 write;
        logic [KM_ADDR_W-1:0] addr;
        logic [KM_DATA_W-1:0] wdata;
    } kmeans_cmd_t;

endpackage

// File: rtl/kmeans_cmd_fifo.sv
// Show-ahead command FIFO: the head entry is readable combinationally the cycle
// after it is pushed. Pushes are refused whenever the FIFO is full.
module kmeans_cmd_fifo
    import kmeans_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  kmeans_cmd_t i_data,
    input  logic        i_pop,
    output kmeans_cmd_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    kmeans_cmd_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kmeans_apb_master.sv
// Host-side APB master for the K-means accelerator: queues commands, runs APB
// transfers, returns read data and latches the completion interrupt.
// Optional ACCESS-phase timeout is enabled by defining KMEANS_APB_TIMEOUT_EN.
module kmeans_apb_master
    import kmeans_pkg::*;
#(
    parameter int ADDR_W      = KM_ADDR_W,
    parameter int DATA_W      = KM_DATA_W,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = KM_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              interupt,
    output logic              done,
    input  logic              done_clr,
    output logic              busy
);

    // The command struct is sized by the package, so the port widths must match it.
    if (ADDR_W != KM_ADDR_W || DATA_W != KM_DATA_W || CMD_DEPTH < 2 ||
        (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("kmeans_apb_master: unsupported parameter combination");
    end

    apb_state_e        r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_int_d;
    logic              r_done;

    kmeans_cmd_t w_push_cmd;
    kmeans_cmd_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_int_rise;

    assign w_push_cmd.write = cmd_write;
    assign w_push_cmd.addr  = cmd_addr;
    assign w_push_cmd.wdata = cmd_wdata;

    // The head is consumed when starting from IDLE or when a transfer completes.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == ACCESS) && pready));

    kmeans_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef KMEANS_APB_TIMEOUT_EN
    localparam int TO_W = to_cnt_width(TIMEOUT_CYC);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_rsp_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef KMEANS_APB_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
`ifdef KMEANS_APB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= w_head.write;
                        r_paddr   <= w_head.addr;
                        r_pwdata  <= w_head.wdata;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
`ifdef KMEANS_APB_TIMEOUT_EN
                    r_to_cnt  <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        if (!r_pwrite) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= prdata;
                        end
                        // Back-to-back: keep psel high and go straight to SETUP.
                        if (!w_empty) begin
                            r_state   <= SETUP;
                            r_penable <= 1'b0;
                            r_pwrite  <= w_head.write;
                            r_paddr   <= w_head.addr;
                            r_pwdata  <= w_head.wdata;
                        end else begin
                            r_state   <= IDLE;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                        end
                    end
`ifdef KMEANS_APB_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_state     <= IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign w_int_rise = interupt && !r_int_d;

    // A new interrupt edge outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_d <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_int_d <= interupt;
            if (w_int_rise) begin
                r_done <= 1'b1;
            end else if (done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign done      = r_done;
    assign busy      = (r_state != IDLE) || !w_empty;

`ifdef KMEANS_APB_TIMEOUT_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_apb_master.sv
// Directed bench for kmeans_apb_master; build with KMEANS_APB_TIMEOUT_EN to add the timeout scenario.
module tb_kmeans_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [8:0]  cmd_addr;
    logic [90:0] cmd_wdata;
    logic        rsp_valid;
    logic [90:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [8:0]  paddr;
    logic [90:0] pwdata;
    logic        pready;
    logic [90:0] prdata;
    logic        interupt;
    logic        done;
    logic        done_clr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    kmeans_apb_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .interupt  (interupt),
        .done      (done),
        .done_clr  (done_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b0; prdata = '0; interupt = 1'b0; done_clr = 1'b0;
        tick(); tick(); tick();
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL rst_psel got=%0h exp=0", psel); end
        total++; if (penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%0h exp=0", penable); end
        total++; if (pwrite !== 1'b0) begin bad++; $display("FAIL rst_pwrite got=%0h exp=0", pwrite); end
        total++; if (paddr !== 9'h0) begin bad++; $display("FAIL rst_paddr got=%0h exp=0", paddr); end
        total++; if (pwdata !== 91'h0) begin bad++; $display("FAIL rst_pwdata got=%0h exp=0", pwdata); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 91'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%0h exp=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%0h exp=0", rsp_err); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        rst = 1'b0;
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0h exp=1", cmd_ready); end
        $display("reset: released");
    endtask

    task automatic test_single_write();
        pready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h010; cmd_wdata = 91'h1;
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL wr_psel_t0 got=%0h exp=0", psel); end
        tick();
        cmd_valid = 1'b0;
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL wr_psel_t1 got=%0h exp=0", psel); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_t1 got=%0h exp=1", busy); end
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b0) begin bad++; $display("FAIL wr_setup_t2 got psel=%0h penable=%0h exp psel=1 penable=0", psel, penable); end
        total++; if (pwrite !== 1'b1 || paddr !== 9'h010) begin bad++; $display("FAIL wr_addr_t2 got pwrite=%0h paddr=%0h exp pwrite=1 paddr=10", pwrite, paddr); end
        total++; if (pwdata !== 91'h1) begin bad++; $display("FAIL wr_pwdata_t2 got=%0h exp=1", pwdata); end
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b1) begin bad++; $display("FAIL wr_access_t3 got psel=%0h penable=%0h exp 1/1", psel, penable); end
        total++; if (paddr !== 9'h010) begin bad++; $display("FAIL wr_addr_hold_t3 got=%0h exp=10", paddr); end
        tick();
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL wr_idle_t4 got psel=%0h penable=%0h exp 0/0", psel, penable); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_no_rsp_t4 got=%0h exp=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_t4 got=%0h exp=0", busy); end
        $display("write: addr=010 data=1 done");
    endtask

    task automatic test_read_wait();
        pready = 1'b0; prdata = 91'h123;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h1FF; cmd_wdata = 91'h0;
        tick();
        cmd_valid = 1'b0;
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 9'h1FF) begin bad++; $display("FAIL rd_setup got psel=%0h penable=%0h pwrite=%0h paddr=%0h exp 1/0/0/1ff", psel, penable, pwrite, paddr); end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (penable !== 1'b1 || psel !== 1'b1) begin bad++; $display("FAIL rd_wait%0d got psel=%0h penable=%0h exp 1/1", i, psel, penable); end
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_rsp%0d got=%0h exp=0", i, rsp_valid); end
            if (i == 3) begin pready = 1'b1; prdata = 91'hABC; end
            tick();
        end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%0h exp=1", rsp_valid); end
        total++; if (rsp_rdata !== 91'hABC) begin bad++; $display("FAIL rd_rsp_rdata got=%0h exp=abc", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rd_rsp_err got=%0h exp=0", rsp_err); end
        pready = 1'b0; prdata = '0;
        tick();
        total++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin bad++; $display("FAIL rd_after got rsp_valid=%0h psel=%0h exp 0/0", rsp_valid, psel); end
        $display("read: addr=1ff data=abc done");
    endtask

    task automatic test_back_to_back();
        logic        exp_w [5];
        logic [8:0]  exp_a [5];
        logic [90:0] exp_d [5];
        logic [90:0] exp_rd;
        int          k;
        int          cyc;
        logic        pend;
        pready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = (i % 2 == 0);
            exp_a[i] = 9'h020 + 9'(i);
            exp_d[i] = 91'h700 + 91'(i);
            cmd_valid = 1'b1; cmd_write = exp_w[i]; cmd_addr = exp_a[i]; cmd_wdata = exp_d[i];
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%0h exp=1", i, cmd_ready); end
            tick();
            $display("push: idx=%0d write=%0b addr=%0h", i, exp_w[i], exp_a[i]);
        end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0h exp=0", cmd_ready); end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h0AA; cmd_wdata = 91'hBAD;
        tick();
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_hold got=%0h exp=0", cmd_ready); end
        total++; if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 9'h020) begin bad++; $display("FAIL b2b_stall got psel=%0h penable=%0h paddr=%0h exp 1/1/20", psel, penable, paddr); end
        pready = 1'b1;
        k = 0; pend = 1'b0; cyc = 0; exp_rd = '0;
        while ((k < 5 || pend) && cyc < 60) begin
            if (pend) begin
                total++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd) begin bad++; $display("FAIL b2b_rsp got valid=%0h rdata=%0h exp valid=1 rdata=%0h", rsp_valid, rsp_rdata, exp_rd); end
                pend = 1'b0;
            end else begin
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_spurious_rsp got=%0h exp=0", rsp_valid); end
            end
            if (k < 5) begin
                total++; if (psel !== 1'b1) begin bad++; $display("FAIL b2b_psel_gap got=%0h exp=1 at xfer %0d", psel, k); end
                if (penable === 1'b1) begin
                    total++; if (paddr !== exp_a[k] || pwrite !== exp_w[k]) begin bad++; $display("FAIL b2b_order%0d got paddr=%0h pwrite=%0h exp paddr=%0h pwrite=%0h", k, paddr, pwrite, exp_a[k], exp_w[k]); end
                    if (exp_w[k]) begin
                        total++; if (pwdata !== exp_d[k]) begin bad++; $display("FAIL b2b_pwdata%0d got=%0h exp=%0h", k, pwdata, exp_d[k]); end
                    end else begin
                        prdata = 91'h5000 + 91'(k);
                        exp_rd = 91'h5000 + 91'(k);
                        pend = 1'b1;
                    end
                    $display("xfer: idx=%0d addr=%0h write=%0b", k, exp_a[k], exp_w[k]);
                    k++;
                end
            end
            tick();
            cyc++;
        end
        total++; if (k !== 5 || pend) begin bad++; $display("FAIL b2b_timeout got xfers=%0d exp=5", k); end
        for (int i = 0; i < 3; i++) begin
            total++; if (psel !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain%0d got psel=%0h busy=%0h rsp_valid=%0h exp 0/0/0", i, psel, busy, rsp_valid); end
            tick();
        end
        pready = 1'b0; prdata = '0;
    endtask

    task automatic test_reset_mid();
        pready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h100 + 9'(i); cmd_wdata = '0;
            tick();
            $display("push: read addr=%0h", 9'h100 + 9'(i));
        end
        cmd_valid = 1'b0;
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b1) begin bad++; $display("FAIL rstmid_access got psel=%0h penable=%0h exp 1/1", psel, penable); end
        rst = 1'b1;
        tick();
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL rstmid_drop got psel=%0h penable=%0h exp 0/0", psel, penable); end
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || paddr !== 9'h0) begin bad++; $display("FAIL rstmid_state got busy=%0h rsp_valid=%0h paddr=%0h exp 0/0/0", busy, rsp_valid, paddr); end
        rst = 1'b0; pready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (psel !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_quiet%0d got psel=%0h rsp_valid=%0h exp 0/0", i, psel, rsp_valid); end
        end
        pready = 1'b0;
        $display("reset: mid-transfer abandoned");
    endtask

    task automatic test_done();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_init got=%0h exp=0", done); end
        interupt = 1'b1; done_clr = 1'b1;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_set_wins got=%0h exp=1", done); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_clear got=%0h exp=0", done); end
        done_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL done_level%0d got=%0h exp=0", i, done); end
        end
        interupt = 1'b0;
        tick();
        interupt = 1'b1;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_rearm got=%0h exp=1", done); end
        interupt = 1'b0; done_clr = 1'b1;
        tick();
        done_clr = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_clear2 got=%0h exp=0", done); end
        $display("done: sticky flag exercised");
    endtask

`ifdef KMEANS_APB_TIMEOUT_EN
    task automatic test_timeout();
        pready = 1'b0; prdata = 91'hDEAD;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h055; cmd_wdata = '0;
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h066; cmd_wdata = 91'h77;
        tick();
        cmd_valid = 1'b0;
        total++; if (psel !== 1'b1 || penable !== 1'b0) begin bad++; $display("FAIL to_setup got psel=%0h penable=%0h exp 1/0", psel, penable); end
        tick();
        for (int i = 0; i < 64; i++) begin
            total++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL to_wait%0d got penable=%0h rsp_valid=%0h exp 1/0", i, penable, rsp_valid); end
            tick();
        end
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin bad++; $display("FAIL to_abort got rsp_valid=%0h rsp_err=%0h exp 1/1", rsp_valid, rsp_err); end
        total++; if (rsp_rdata !== 91'h0 || psel !== 1'b0) begin bad++; $display("FAIL to_abort_data got rdata=%0h psel=%0h exp 0/0", rsp_rdata, psel); end
        tick();
        total++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 9'h066 || pwrite !== 1'b1) begin bad++; $display("FAIL to_next got psel=%0h penable=%0h paddr=%0h pwrite=%0h exp 1/0/66/1", psel, penable, paddr, pwrite); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL to_rsp_pulse got valid=%0h err=%0h exp 0/0", rsp_valid, rsp_err); end
        tick();
        pready = 1'b1;
        tick();
        total++; if (psel !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_finish got psel=%0h rsp_valid=%0h busy=%0h exp 0/0/0", psel, rsp_valid, busy); end
        pready = 1'b0; prdata = '0;
        $display("timeout: read aborted, write completed");
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_reset_mid();
        test_done();
`ifdef KMEANS_APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
